esm_instr_window: RTL and testbench

Holds up to `bs` fetched instructions in an unordered window and tracks their relative age. Each cycle it publishes the per-slot independence vector, which the ESM core's candidate-list synchronizer consumes. It accepts issue requests by slot index from the ESM core's `next_buffer_index`/`valid_count` path and retires the selected instruction to the execute side. It sits directly upstream of the ESM core: it produces `independent_instr` and consumes the core's index selection.

---
 rtl/esm_instr_window.sv | 129 ++++++++++++
 tb/tb_esm_instr_window.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/esm_instr_window.sv
// Unordered instruction window with an age matrix: publishes per-slot independence
// to the ESM core and issues the slot it selects, rejecting stale or blocked picks.
module esm_instr_window #(
    parameter int bs = 16,
    parameter int IW = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IW-1:0]          in_instr,
    input  logic                   issue_req,
    input  logic [$clog2(bs)-1:0]  issue_index,
    output logic [0:bs-1]          independent_instr,
    output logic                   out_valid,
    output logic [IW-1:0]          out_instr,
    output logic [$clog2(bs)-1:0]  out_index,
    output logic                   issue_err,
    output logic [$clog2(bs):0]    occupancy
);

    localparam int          IDXW = $clog2(bs);
    localparam int          OCW  = IDXW + 1;
    localparam int unsigned BSU  = bs;
    localparam logic [OCW-1:0] FULL = OCW'(bs);

    logic [bs-1:0]   valid;
    logic [IW-1:0]   instr [bs];
    logic [bs-1:0]   older [bs];

    logic [4:0]      rd  [bs];
    logic [4:0]      rs1 [bs];
    logic [4:0]      rs2 [bs];
    logic [0:bs-1]   ind;
    logic [IDXW-1:0] ins_slot;
    logic            found;
    logic            do_ins;
    logic            accept;

    // Hazard of an older entry (o) against a younger one (y); x0 never conflicts.
    function automatic logic hazard(
        input logic [4:0] rd_o, input logic [4:0] rs1_o, input logic [4:0] rs2_o,
        input logic [4:0] rd_y, input logic [4:0] rs1_y, input logic [4:0] rs2_y
    );
        logic raw, waw, war;
        raw = (rd_o != 5'd0) && ((rd_o == rs1_y) || (rd_o == rs2_y));
        waw = (rd_y != 5'd0) && (rd_y == rd_o);
        war = (rd_y != 5'd0) && ((rd_y == rs1_o) || (rd_y == rs2_o));
        return raw | waw | war;
    endfunction

    always_comb begin
        for (int unsigned k = 0; k < BSU; k++) begin
            rd[k]  = instr[k][11:7];
            rs1[k] = instr[k][19:15];
            rs2[k] = instr[k][24:20];
        end
    end

    always_comb begin
        ind = '0;
        for (int unsigned i = 0; i < BSU; i++) begin
            ind[i] = valid[i];
            for (int unsigned j = 0; j < BSU; j++) begin
                if (older[i][j] && valid[j] &&
                    hazard(rd[j], rs1[j], rs2[j], rd[i], rs1[i], rs2[i]))
                    ind[i] = 1'b0;
            end
        end
    end

    always_comb begin
        ins_slot = '0;
        found    = 1'b0;
        for (int unsigned k = 0; k < BSU; k++) begin
            if (!valid[k] && !found) begin
                ins_slot = IDXW'(k);
                found    = 1'b1;
            end
        end
    end

    assign in_ready = ~rst & (occupancy < FULL);
    assign do_ins   = in_valid & in_ready;
    assign accept   = issue_req & valid[issue_index] & ind[issue_index];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid             <= '0;
            independent_instr <= '0;
            out_valid         <= 1'b0;
            out_instr         <= '0;
            out_index         <= '0;
            issue_err         <= 1'b0;
            occupancy         <= '0;
            for (int unsigned i = 0; i < BSU; i++)
                older[i] <= '0;
        end else begin
            independent_instr <= ind;
            out_valid         <= accept;
            issue_err         <= issue_req & ~accept;

            if (accept) begin
                out_instr          <= instr[issue_index];
                out_index          <= issue_index;
                valid[issue_index] <= 1'b0;
                for (int unsigned i = 0; i < BSU; i++)
                    older[i][issue_index] <= 1'b0;
            end

            // New row sees every still-valid slot as older, excluding one issued this edge.
            if (do_ins) begin
                valid[ins_slot] <= 1'b1;
                instr[ins_slot] <= in_instr;
                for (int unsigned j = 0; j < BSU; j++)
                    older[ins_slot][j] <= valid[j] & ~(accept && (issue_index == IDXW'(j)));
                for (int unsigned i = 0; i < BSU; i++)
                    older[i][ins_slot] <= 1'b0;
            end

            case ({do_ins, accept})
                2'b10:   occupancy <= occupancy + OCW'(1);
                2'b01:   occupancy <= occupancy - OCW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_esm_instr_window.sv
// Scoreboard bench for esm_instr_window: an age-ordered list model predicts
// issue responses, occupancy, in_ready and the independence vector.
module tb_esm_instr_window;

    localparam int BS = 16;
    localparam int IW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [IW-1:0] in_instr = '0;
    logic          issue_req = 1'b0;
    logic [3:0]    issue_index = '0;
    logic [0:BS-1] independent_instr;
    logic          out_valid;
    logic [IW-1:0] out_instr;
    logic [3:0]    out_index;
    logic          issue_err;
    logic [4:0]    occupancy;

    always #5 clk = ~clk;

    esm_instr_window #(.bs(BS), .IW(IW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .issue_req(issue_req), .issue_index(issue_index),
        .independent_instr(independent_instr), .out_valid(out_valid),
        .out_instr(out_instr), .out_index(out_index), .issue_err(issue_err),
        .occupancy(occupancy)
    );

    typedef struct {
        bit          ok;
        logic [31:0] instr;
        logic [3:0]  idx;
    } resp_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    bit          armed   = 0;
    logic [31:0] m_instr [BS];
    int          age_q [$];
    resp_t       sb [$];
    logic [31:0] hold_instr = '0;
    logic [3:0]  hold_idx   = '0;

    function automatic logic [31:0] mk(int rd, int rs1, int rs2);
        logic [31:0] v;
        v = 32'h0000_0033;
        v[11:7]  = 5'(rd);
        v[19:15] = 5'(rs1);
        v[24:20] = 5'(rs2);
        return v;
    endfunction

    function automatic bit haz(logic [31:0] o, logic [31:0] y);
        bit raw, waw, war;
        raw = (o[11:7] != 0) && (o[11:7] == y[19:15] || o[11:7] == y[24:20]);
        waw = (y[11:7] != 0) && (y[11:7] == o[11:7]);
        war = (y[11:7] != 0) && (y[11:7] == o[19:15] || y[11:7] == o[24:20]);
        return raw || waw || war;
    endfunction

    // An entry is independent when nothing ahead of it in age order conflicts.
    function automatic logic [0:BS-1] ind_vec();
        logic [0:BS-1] v;
        bit ok;
        v = '0;
        for (int p = 0; p < age_q.size(); p++) begin
            ok = 1;
            for (int q = 0; q < p; q++)
                if (haz(m_instr[age_q[q]], m_instr[age_q[p]])) ok = 0;
            v[age_q[p]] = ok;
        end
        return v;
    endfunction

    function automatic bit in_window(int s);
        foreach (age_q[p]) if (age_q[p] == s) return 1;
        return 0;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive after a falling edge, predict, advance, check state outputs.
    task automatic step(bit r, bit iv, logic [31:0] ii, bit ir, int ix);
        logic [0:BS-1] exp_ind;
        bit acc, ins;
        int slot;
        rst = r; in_valid = iv; in_instr = ii; issue_req = ir; issue_index = 4'(ix);
        #1;
        check("in_ready", in_ready, (!r && age_q.size() < BS));
        exp_ind = r ? '0 : ind_vec();
        acc  = !r && ir && in_window(ix) && exp_ind[ix];
        ins  = !r && iv && age_q.size() < BS;
        slot = -1;
        for (int s = BS - 1; s >= 0; s--) if (!in_window(s)) slot = s;
        @(posedge clk);
        if (r) begin
            age_q.delete();
            hold_instr = '0;
            hold_idx   = '0;
        end else begin
            if (ir) sb.push_back('{acc, m_instr[ix], 4'(ix)});
            if (acc) begin
                foreach (age_q[p]) if (age_q[p] == ix) begin age_q.delete(p); break; end
            end
            if (ins) begin
                m_instr[slot] = ii;
                age_q.push_back(slot);
            end
        end
        @(negedge clk);
        armed = 1;
        check("occupancy", occupancy, age_q.size());
        check("independent_instr", independent_instr, exp_ind);
    endtask

    task automatic idle(int n);
        repeat (n) step(0, 0, '0, 0, 0);
    endtask

    task automatic ins(logic [31:0] ii);
        step(0, 1, ii, 0, 0);
    endtask

    task automatic iss(int ix);
        step(0, 0, '0, 1, ix);
    endtask

    always @(negedge clk) begin
        resp_t r;
        if (armed) begin
            if (out_valid === 1'b1 || issue_err === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_pulse", {out_valid, issue_err}, 2'b00);
                end else begin
                    r = sb.pop_front();
                    check("out_valid", out_valid, r.ok);
                    check("issue_err", issue_err, !r.ok);
                    if (r.ok) begin
                        check("out_instr", out_instr, r.instr);
                        check("out_index", out_index, r.idx);
                        hold_instr = r.instr;
                        hold_idx   = r.idx;
                    end
                end
            end else begin
                if (sb.size() != 0) begin
                    r = sb.pop_front();
                    check("missing_response", {out_valid, issue_err}, r.ok ? 2'b10 : 2'b01);
                end
                check("out_instr_hold", out_instr, hold_instr);
                check("out_index_hold", out_index, hold_idx);
            end
        end
    end

    initial begin
        int p_ins;
        logic [0:BS-1] v;
        int cand [$];
        bit r, iv, ir;
        int ix;
        logic [31:0] ii;

        @(negedge clk);
        step(1, 0, '0, 0, 0);

        // Four independent writers fill slots 0..3
        for (int k = 1; k <= 4; k++) ins(mk(k, 0, 0));
        idle(2);

        // RAW pair: B waits for A
        step(1, 0, '0, 0, 0);
        ins(mk(5, 0, 0));
        ins(mk(0, 5, 0));
        idle(2);
        iss(0);
        idle(2);
        iss(1);
        idle(1);

        // Full window, issue under back-pressure, refill lands youngest in slot 3
        step(1, 0, '0, 0, 0);
        for (int k = 0; k < BS; k++) ins(mk(0, k % 8, (k + 1) % 8));
        idle(1);
        step(0, 1, mk(2, 0, 0), 1, 3);
        ins(mk(2, 0, 0));
        idle(2);
        iss(3);
        idle(1);

        // Empty-slot and RAW-blocked rejections
        step(1, 0, '0, 0, 0);
        iss(0);
        ins(mk(5, 0, 0));
        ins(mk(0, 5, 0));
        idle(2);
        iss(1);
        idle(1);

        // WAW, WAR and x0 pairs
        step(1, 0, '0, 0, 0);
        ins(mk(7, 0, 0));
        ins(mk(7, 0, 0));
        ins(mk(0, 0, 8));
        ins(mk(8, 0, 0));
        ins(mk(0, 3, 3));
        ins(mk(0, 3, 3));
        idle(2);
        iss(1);
        iss(3);
        iss(0);
        iss(2);
        idle(2);
        iss(1);
        iss(3);
        iss(4);
        iss(5);
        idle(1);

        // Reset with ten entries held
        for (int k = 0; k < 10; k++) ins(mk(k % 8, 0, 0));
        step(1, 0, '0, 0, 0);
        idle(2);

        p_ins = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) p_ins = $urandom_range(20, 90);
            r  = ($urandom_range(0, 299) == 0);
            iv = ($urandom_range(0, 99) < p_ins);
            ii = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7))
                 | ($urandom & 32'hFE00_707F);
            ir = ($urandom_range(0, 99) < 60);
            ix = $urandom_range(0, BS - 1);
            if ($urandom_range(0, 1) == 1) begin
                v = ind_vec();
                cand.delete();
                for (int s = 0; s < BS; s++) if (v[s]) cand.push_back(s);
                if (cand.size() > 0) ix = cand[$urandom_range(0, cand.size() - 1)];
            end
            step(r, iv, ii, ir, ix);
        end

        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
